// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port register file with two write ports
// (port A has priority), a per-register pending scoreboard, and a
// clear-all sweep FSM that zeroes one register per cycle.
// Optional feature macro: REGFILE_BYPASS_EN forwards accepted same-cycle
// write data to the read ports; when undefined, reads see stored data only.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [RD_PORTS*ADDR_W-1:0] raddr,
    output logic [RD_PORTS*DATA_W-1:0] rdata,
    output logic [RD_PORTS-1:0]        rpend,
    input  logic                       wen_a,
    input  logic [ADDR_W-1:0]          wadr_a,
    input  logic [DATA_W-1:0]          wdata_a,
    input  logic                       wen_b,
    input  logic [ADDR_W-1:0]          wadr_b,
    input  logic [DATA_W-1:0]          wdata_b,
    input  logic                       pend_set,
    input  logic [ADDR_W-1:0]          pend_adr,
    input  logic                       clear_req,
    output logic                       busy
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam bit                ZERO_EN  = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] ADR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state_r;
    logic [ADDR_W-1:0]  cnt_r;
    logic               busy_r;
    logic [DATA_W-1:0]  regs_r [DEPTH];
    logic [DEPTH-1:0]   pend_r;

    logic               acc_a_s;
    logic               acc_b_s;
    logic               acc_p_s;

    assign busy = busy_r;

    // Qualify write and pend requests: dropped while sweeping, register 0 is
    // read-only when hardwired, and port B loses to port A on the same address.
    always_comb begin
        acc_a_s = 1'b0;
        acc_b_s = 1'b0;
        acc_p_s = 1'b0;
        if (!busy_r) begin
            acc_a_s = wen_a && !(ZERO_EN && (wadr_a == ADR_ZERO));
            acc_b_s = wen_b && !(ZERO_EN && (wadr_b == ADR_ZERO))
                      && !(acc_a_s && (wadr_b == wadr_a));
            acc_p_s = pend_set && !(ZERO_EN && (pend_adr == ADR_ZERO));
        end else begin
            acc_a_s = 1'b0;
            acc_b_s = 1'b0;
            acc_p_s = 1'b0;
        end
    end

    // Combinational read ports with zero-register masking and optional forwarding.
    always_comb begin
        rdata = {(RD_PORTS*DATA_W){1'b0}};
        rpend = {RD_PORTS{1'b0}};
        for (int i = 0; i < RD_PORTS; i++) begin
            if (ZERO_EN && (raddr[i*ADDR_W +: ADDR_W] == ADR_ZERO)) begin
                rdata[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rpend[i]                  = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (acc_a_s && (raddr[i*ADDR_W +: ADDR_W] == wadr_a)) begin
                rdata[i*DATA_W +: DATA_W] = wdata_a;
                rpend[i]                  = acc_p_s && (pend_adr == wadr_a);
            end else if (acc_b_s && (raddr[i*ADDR_W +: ADDR_W] == wadr_b)) begin
                rdata[i*DATA_W +: DATA_W] = wdata_b;
                rpend[i]                  = acc_p_s && (pend_adr == wadr_b);
            end
`endif
            else begin
                rdata[i*DATA_W +: DATA_W] = regs_r[raddr[i*ADDR_W +: ADDR_W]];
                rpend[i]                  = pend_r[raddr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Storage, scoreboard and sweep FSM; reset overrides every other request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= ADR_ZERO;
            busy_r  <= 1'b0;
            pend_r  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (acc_b_s) begin
                        regs_r[wadr_b] <= wdata_b;
                        pend_r[wadr_b] <= 1'b0;
                    end
                    if (acc_a_s) begin
                        regs_r[wadr_a] <= wdata_a;
                        pend_r[wadr_a] <= 1'b0;
                    end
                    // Placed after the write clears so a same-address set wins.
                    if (acc_p_s) begin
                        pend_r[pend_adr] <= 1'b1;
                    end
                    if (clear_req) begin
                        state_r <= CLEAR;
                        cnt_r   <= ADR_ZERO;
                        busy_r  <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs_r[cnt_r] <= {DATA_W{1'b0}};
                    pend_r[cnt_r] <= 1'b0;
                    if (cnt_r == ADR_LAST) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= ADR_ZERO;
                    end else begin
                        cnt_r <= cnt_r + ADR_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= ADR_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: reference model of memory,
// scoreboard and sweep; directed vector table, sweep sequences, random run.
module tb_register_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int RP    = 4;
    localparam int DEPTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [RP*AW-1:0] raddr;
    logic [RP*DW-1:0] rdata;
    logic [RP-1:0]    rpend;
    logic             wen_a, wen_b, pend_set, clear_req;
    logic [AW-1:0]    wadr_a, wadr_b, pend_adr;
    logic [DW-1:0]    wdata_a, wdata_b;
    logic             busy;

    register_file_mp dut (
        .clock    (clock),
        .reset    (reset),
        .raddr    (raddr),
        .rdata    (rdata),
        .rpend    (rpend),
        .wen_a    (wen_a),
        .wadr_a   (wadr_a),
        .wdata_a  (wdata_a),
        .wen_b    (wen_b),
        .wadr_b   (wadr_b),
        .wdata_b  (wdata_b),
        .pend_set (pend_set),
        .pend_adr (pend_adr),
        .clear_req(clear_req),
        .busy     (busy)
    );

    // Free-running clock, 10 ns period.
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_pend [DEPTH];
    bit            m_busy;
    int            m_idx;

    typedef struct {
        bit            wa; logic [AW-1:0] aa; logic [DW-1:0] da;
        bit            wb; logic [AW-1:0] ab; logic [DW-1:0] db;
        bit            ps; logic [AW-1:0] pa;
        logic [AW-1:0] ra; logic [DW-1:0] exp_d; bit exp_p;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    // Expected read value of address a given model state and current inputs.
    function automatic void model_read(input int a, output logic [DW-1:0] d, output bit p);
        d = m_mem[a];
        p = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (!m_busy && a != 0) begin
            if (wen_a && int'(wadr_a) == a) begin
                d = wdata_a;
                p = pend_set && int'(pend_adr) == a;
            end else if (wen_b && int'(wadr_b) == a) begin
                d = wdata_b;
                p = pend_set && int'(pend_adr) == a;
            end
        end
`endif
        if (a == 0) begin
            d = '0;
            p = 1'b0;
        end
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_busy = 1'b0;
            m_idx  = 0;
        end else if (m_busy) begin
            m_mem[m_idx]  = '0;
            m_pend[m_idx] = 1'b0;
            if (m_idx == DEPTH - 1) m_busy = 1'b0;
            else m_idx++;
        end else begin
            if (wen_b && wadr_b != 0) begin
                m_mem[wadr_b]  = wdata_b;
                m_pend[wadr_b] = 1'b0;
            end
            if (wen_a && wadr_a != 0) begin
                m_mem[wadr_a]  = wdata_a;
                m_pend[wadr_a] = 1'b0;
            end
            if (pend_set && pend_adr != 0) m_pend[pend_adr] = 1'b1;
            if (clear_req) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
    endtask

    // One cycle: compare all outputs to the model, take the edge, step the model.
    task automatic tick();
        logic [DW-1:0] d;
        bit            p;
        #1;
        if (check_en) begin
            chk("busy", 0, busy, m_busy);
            for (int i = 0; i < RP; i++) begin
                model_read(int'(raddr[i*AW +: AW]), d, p);
                chk("rdata", i, rdata[i*DW +: DW], d);
                chk("rpend", i, rpend[i], p);
            end
        end
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 1'b0; clear_req = 1'b0;
        wen_a = 1'b0; wadr_a = '0; wdata_a = '0;
        wen_b = 1'b0; wadr_b = '0; wdata_b = '0;
        pend_set = 1'b0; pend_adr = '0;
    endtask

    function automatic logic [AW-1:0] radr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic fill_all();
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            wen_a = 1'b1; wadr_a = AW'(a); wdata_a = 32'h1000 + 32'(a);
            pend_set = 1'b1; pend_adr = AW'(DEPTH - 1 - a);
            tick();
        end
        idle();
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {RP{AW'(a)}};
            #1;
            chk(name, a, rdata[DW-1:0], 64'h0);
            chk(name, a, rpend[0], 64'h0);
            tick();
        end
    endtask

    // Global bound so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    // Main stimulus sequence.
    initial begin
        int n;
        vt[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0, 5'd3,  32'hDEADBEEF, 1'b0};
        vt[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  32'h0,        1'b0};
        vt[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  32'h0,        1'b1};
        vt[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h55,       1'b0, 5'd0, 5'd7,  32'h55,       1'b0};
        vt[4] = '{1'b1, 5'd7,  32'h66,       1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  32'h66,       1'b1};
        vt[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  32'h0,        1'b0};
        vt[6] = '{1'b1, 5'd31, 32'h1,        1'b1, 5'd30, 32'h2,        1'b0, 5'd0, 5'd30, 32'h2,        1'b0};
        vt[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'h77,       1'b0, 5'd0, 5'd31, 32'h77,       1'b0};

        idle();
        reset = 1'b1;
        raddr = '0;
        @(negedge clock);
        tick();
        tick();
        check_en = 1'b1;
        idle();

        // Reset state across every address on all ports
        for (int a = 0; a < DEPTH; a++) begin
            for (int p = 0; p < RP; p++) raddr[p*AW +: AW] = AW'((a + p) % DEPTH);
            tick();
        end
        read_all_zero("rst_read");

        // Directed vector table: apply one cycle, read back the next
        for (int v = 0; v < 8; v++) begin
            idle();
            wen_a = vt[v].wa; wadr_a = vt[v].aa; wdata_a = vt[v].da;
            wen_b = vt[v].wb; wadr_b = vt[v].ab; wdata_b = vt[v].db;
            pend_set = vt[v].ps; pend_adr = vt[v].pa;
            tick();
            idle();
            raddr = {RP{vt[v].ra}};
            #1;
            chk("vec_rdata", v, rdata[DW-1:0], vt[v].exp_d);
            chk("vec_rpend", v, rpend[0], vt[v].exp_p);
            tick();
        end

        // Same-cycle read of a register being written
        idle();
        wen_a = 1'b1; wadr_a = 5'd9; wdata_a = 32'h0BADF00D;
        tick();
        idle();
        wen_a = 1'b1; wadr_a = 5'd9; wdata_a = 32'hA5A5A5A5;
        raddr = {RP{5'd9}};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same", 0, rdata[DW-1:0], 64'hA5A5A5A5);
`else
        chk("byp_same", 0, rdata[DW-1:0], 64'h0BADF00D);
`endif
        tick();
        idle();
        #1;
        chk("byp_next", 0, rdata[DW-1:0], 64'hA5A5A5A5);
        tick();

        // Full sweep with writes and pend_set hammering during busy
        fill_all();
        clear_req = 1'b1;
        tick();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            wen_a = 1'b1; wadr_a = radr(); wdata_a = $urandom | 32'h1;
            wen_b = 1'b1; wadr_b = radr(); wdata_b = $urandom | 32'h1;
            pend_set = 1'b1; pend_adr = radr();
            clear_req = 1'b1;
            for (int p = 0; p < RP; p++) raddr[p*AW +: AW] = radr();
            tick();
            n++;
        end
        chk("sweep_len", 0, 64'(n), 64'd32);
        idle();
        read_all_zero("swept");

        // Reset in the middle of a sweep
        fill_all();
        clear_req = 1'b1;
        tick();
        idle();
        for (int c = 1; c < 10; c++) begin
            wen_b = 1'b1; wadr_b = radr(); wdata_b = $urandom | 32'h1;
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        idle();
        #1;
        chk("rst_mid_busy", 0, busy, 64'h0);
        read_all_zero("rst_mid");

        // Randomized run against the model
        for (int c = 0; c < 600; c++) begin
            wen_a = ($urandom_range(0, 1) == 1); wadr_a = radr(); wdata_a = $urandom;
            wen_b = ($urandom_range(0, 1) == 1); wadr_b = radr(); wdata_b = $urandom;
            pend_set = ($urandom_range(0, 2) == 0); pend_adr = radr();
            clear_req = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < RP; p++) raddr[p*AW +: AW] = radr();
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
